// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous RAM between two requesters: the CPU data
// port and a loader/DMA port. Each access takes three cycles:
//   IDLE     -> arbitration; the winner's wr/addr/wdata are captured
//   ACC_x    -> RAM command is presented (mem_en=1) for exactly one cycle
//   RESP_x   -> x_ack pulses; on a read x_rdata takes mem_rdata
// The loser of a tie waits with its request held. Its inputs are not looked at
// until it wins. A request that drops before it is granted disappears without
// touching memory.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties. The requester not granted
//                               last wins. After reset the CPU wins the first tie.
//                  undefined -> fixed priority, CPU over DMA; no last-grant state.
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    synchronous, active-low reset
//   cpu_req/cpu_wr           CPU request (held until cpu_ack) and direction
//   cpu_addr/cpu_wdata       CPU address and write data
//   cpu_rdata                CPU read data, valid in the ack cycle, then held
//   cpu_ack                  one-cycle completion pulse for the CPU
//   cpu_stall                cpu_req & ~cpu_ack (combinational)
//   dma_*                    same meaning for the loader/DMA requester
//   mem_en/mem_we            registered RAM enable and write-enable
//   mem_addr/mem_wdata       registered RAM address and write data
//   mem_rdata                RAM read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,

    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACC_CPU  = 3'd1,
        ACC_DMA  = 3'd2,
        RESP_CPU = 3'd3,
        RESP_DMA = 3'd4
    } state_e;

    state_e      state_q,     state_d;
    logic        mem_en_q,    mem_en_d;
    logic        mem_we_q,    mem_we_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        op_wr_q,     op_wr_d;     // direction of the access in flight
    logic        cpu_ack_q,   cpu_ack_d;
    logic        dma_ack_q,   dma_ack_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;

    logic        grant_cpu;
    logic        grant_dma;

    // -------------------------------------------------------------------------
    // Arbitration. Only evaluated by the FSM in IDLE.
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    logic last_grant_dma_q, last_grant_dma_d;   // 1: DMA was granted last

    always_comb begin
        // On a tie, the CPU wins only if the DMA had the previous grant.
        grant_cpu = cpu_req & (~dma_req | last_grant_dma_q);
        grant_dma = dma_req & ~grant_cpu;
    end

    always_comb begin
        last_grant_dma_d = last_grant_dma_q;
        if (state_q == IDLE) begin
            if (grant_cpu) begin
                last_grant_dma_d = 1'b0;
            end else if (grant_dma) begin
                last_grant_dma_d = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant_cpu = cpu_req;
        grant_dma = dma_req & ~cpu_req;
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // NOTE: every signal gets a default before the case statement. A path that
    // leaves a signal unassigned in always_comb would infer a latch.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        op_wr_d     = op_wr_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The command registers double as the request latches. They
                // load on the transition into ACC_x, so mem_en appears one
                // cycle after the request is sampled.
                if (grant_cpu) begin
                    state_d     = ACC_CPU;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_wr;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    op_wr_d     = cpu_wr;
                end else if (grant_dma) begin
                    state_d     = ACC_DMA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dma_wr;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    op_wr_d     = dma_wr;
                end
            end
            ACC_CPU: begin
                state_d   = RESP_CPU;
                cpu_ack_d = 1'b1;
            end
            ACC_DMA: begin
                state_d   = RESP_DMA;
                dma_ack_d = 1'b1;
            end
            RESP_CPU,
            RESP_DMA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The RAM returns read data in the RESP cycle, which is also the ack cycle.
    // Pass it straight through while responding to a read. Otherwise show the
    // held copy from the last completed read.
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (state_q == RESP_CPU && !op_wr_q) begin
            cpu_rdata_d = mem_rdata;
        end
        if (state_q == RESP_DMA && !op_wr_q) begin
            dma_rdata_d = mem_rdata;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // NOTE: non-blocking assignments here, so every flop samples the values
    // from before the edge no matter what order the statements are in.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            // Reset abandons any access in flight. No ack is issued, and
            // mem_en is low from the next cycle on.
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            op_wr_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
`ifdef MEM_ARB_RR_EN
            last_grant_dma_q <= 1'b1;   // CPU takes the first tie after reset
`endif
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            op_wr_q     <= op_wr_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_dma_q <= last_grant_dma_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_d;
    assign dma_rdata = dma_rdata_d;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. It includes a synchronous RAM with a one-cycle read
// latency. The reference model works at the transaction level:
//   - a shadow memory (associative array) updated once per granted access;
//   - an arbitration rule function: fixed priority, or round-robin when
//     MEM_ARB_RR_EN is defined;
//   - a "busy" cycle budget for the three-cycle access slot.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dma_req, dma_wr;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic        dma;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    // RAM environment plus the shadow memory used by the model
    logic [15:0] ram [0:65535];
    logic [15:0] ref_mem [logic [15:0]];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0, pre_data = '0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_wr    (dma_wr),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Arbitration rule: returns 1 when the DMA should win.
    function automatic bit pick_dma(input bit c, input bit d, input bit last_dma);
        if (c && d) return RR_MODE ? !last_dma : 1'b0;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // One access from either requester, waiting at most 8 cycles for the ack.
    task automatic do_access(input bit use_dma, input bit wr, input logic [15:0] a,
                             input logic [15:0] d, output logic [15:0] rd, output bit ok);
        ok = 1'b0;
        rd = 'x;
        if (use_dma) begin dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d; end
        else         begin cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
        for (int k = 0; k < 8 && !ok; k++) begin
            tick();
            if (use_dma ? dma_ack : cpu_ack) begin
                ok = 1'b1;
                rd = use_dma ? dma_rdata : cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        dma_req = 1'b1; dma_wr = 1'($urandom_range(0, 1));
        dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
        tick();
        tick();
        total++;
        if ({mem_en, mem_we, cpu_ack, dma_ack} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_we, cpu_ack, dma_ack});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            bad++; $display("FAIL reset_cmd: got %h want 00000000", {mem_addr, mem_wdata});
        end
        total++;
        if ({cpu_rdata, dma_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h want 00000000", {cpu_rdata, dma_rdata});
        end
        total++;
        if (cpu_stall !== 1'b1) begin
            bad++; $display("FAIL reset_stall: got %b want 1", cpu_stall);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        total++;
        if ({mem_en, cpu_ack, dma_ack, cpu_stall} !== 4'b0000) begin
            bad++; $display("FAIL reset_idle: got %b want 0000", {mem_en, cpu_ack, dma_ack, cpu_stall});
        end
    endtask

    // CPU read of 0x0010 returning 0xBEEF with the N / N+1 / N+2 timing.
    task automatic test_cpu_read();
        preload(16'h0010, 16'hBEEF);
        cpu_wr = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        #1;
        total++;
        if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall_n: got %b want 1", cpu_stall); end
        tick();   // N+1
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++; $display("FAIL rd_cmd_n1: got en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr);
        end
        total++;
        if ({cpu_ack, cpu_stall} !== 2'b01) begin
            bad++; $display("FAIL rd_ack_n1: got ack=%b stall=%b want 0 1", cpu_ack, cpu_stall);
        end
        tick();   // N+2
        total++;
        if ({cpu_ack, dma_ack, mem_en, cpu_stall} !== 4'b1000) begin
            bad++; $display("FAIL rd_ack_n2: got ack=%b dack=%b en=%b stall=%b want 1 0 0 0",
                            cpu_ack, dma_ack, mem_en, cpu_stall);
        end
        total++;
        if (cpu_rdata !== ref_mem[16'h0010]) begin
            bad++; $display("FAIL rd_data: got %h want %h", cpu_rdata, ref_mem[16'h0010]);
        end
        cpu_req = 1'b0;
        tick();
        total++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, ref_mem[16'h0010]}) begin
            bad++; $display("FAIL rd_hold: got ack=%b data=%h want 0 %h", cpu_ack, cpu_rdata, ref_mem[16'h0010]);
        end
    endtask

    // DMA write of 0x1234 to 0x4000, then a CPU read-back.
    task automatic test_dma_write();
        logic [15:0] rd;
        bit          ok;
        logic [15:0] cpu_rd_before;
        cpu_rd_before = cpu_rdata;
        dma_wr = 1'b1; dma_addr = 16'h4000; dma_wdata = 16'h1234; dma_req = 1'b1;
        tick();   // N+1
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h4000, 16'h1234}) begin
            bad++; $display("FAIL wr_cmd: got en=%b we=%b addr=%h data=%h want 1 1 4000 1234",
                            mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();   // N+2
        ref_mem[16'h4000] = 16'h1234;
        total++;
        if ({dma_ack, cpu_ack, mem_en} !== 3'b100) begin
            bad++; $display("FAIL wr_ack: got dack=%b cack=%b en=%b want 1 0 0", dma_ack, cpu_ack, mem_en);
        end
        total++;
        if ({dma_rdata, cpu_rdata} !== {16'h0000, cpu_rd_before}) begin
            bad++; $display("FAIL wr_rdata_hold: got %h %h want 0000 %h", dma_rdata, cpu_rdata, cpu_rd_before);
        end
        dma_req = 1'b0;
        tick();
        do_access(1'b0, 1'b0, 16'h4000, 16'h0000, rd, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wr_readback_timeout: got no ack want ack"); end
        total++;
        if (rd !== 16'h1234) begin bad++; $display("FAIL wr_readback: got %h want 1234", rd); end
    endtask

    // Both requests held high over four grants.
    task automatic test_priority();
        bit exp_order [4];
        bit got [$];
        bit last;
        apply_reset();
        last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_order[k] = pick_dma(1'b1, 1'b1, last);
            last = exp_order[k];
        end
        cpu_wr = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        dma_wr = 1'b0; dma_addr = 16'h4000; dma_req = 1'b1;
        for (int k = 0; k < 30 && got.size() < 4; k++) begin
            tick();
            total++;
            if (cpu_ack && dma_ack) begin bad++; $display("FAIL prio_two_acks: got 11 want at most one"); end
            if (cpu_ack) begin
                got.push_back(1'b0);
                total++;
                if (cpu_rdata !== ref_mem[16'h0010]) begin
                    bad++; $display("FAIL prio_cpu_data: got %h want %h", cpu_rdata, ref_mem[16'h0010]);
                end
            end
            if (dma_ack) begin
                got.push_back(1'b1);
                total++;
                if (dma_rdata !== ref_mem[16'h4000]) begin
                    bad++; $display("FAIL prio_dma_data: got %h want %h", dma_rdata, ref_mem[16'h4000]);
                end
            end
        end
        idle_inputs();
        tick();
        total++;
        if (got.size() != 4) begin
            bad++; $display("FAIL prio_timeout: got %0d grants want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got[k] !== exp_order[k]) begin
                    bad++; $display("FAIL prio_order[%0d]: got %s want %s", k,
                                    got[k] ? "DMA" : "CPU", exp_order[k] ? "DMA" : "CPU");
                end
            end
        end
    endtask

    // Reset arriving while the CPU access is in ACC_CPU.
    task automatic test_reset_abort();
        cpu_wr = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
        tick();   // ACC_CPU
        total++;
        if (mem_en !== 1'b1) begin bad++; $display("FAIL abort_acc: got en=%b want 1", mem_en); end
        reset = 1'b0;
        cpu_req = 1'b0;
        tick();
        total++;
        if ({cpu_ack, dma_ack, mem_en, mem_we} !== 4'b0000) begin
            bad++; $display("FAIL abort_ctrl: got %b want 0000", {cpu_ack, dma_ack, mem_en, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 64'h0) begin
            bad++; $display("FAIL abort_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({cpu_ack, dma_ack, mem_en} !== 3'b000) begin
                bad++; $display("FAIL abort_quiet[%0d]: got %b want 000", k, {cpu_ack, dma_ack, mem_en});
            end
        end
        // mem_en must follow one cycle after the request, which shows the FSM is back in IDLE.
        cpu_req = 1'b1;
        tick();
        total++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0010}) begin
            bad++; $display("FAIL abort_idle: got en=%b addr=%h want 1 0010", mem_en, mem_addr);
        end
        tick();
        total++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, ref_mem[16'h0010]}) begin
            bad++; $display("FAIL abort_resume: got ack=%b data=%h want 1 %h", cpu_ack, cpu_rdata, ref_mem[16'h0010]);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    // A one-cycle DMA pulse while the CPU is being served must be dropped.
    task automatic test_dma_drop();
        int en_cnt = 0;
        int dack_cnt = 0;
        cpu_wr = 1'b0; cpu_addr = 16'h4000; cpu_req = 1'b1;
        tick();   // ACC_CPU
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'($urandom);
        tick();   // RESP_CPU
        dma_req = 1'b0;
        total++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, ref_mem[16'h4000]}) begin
            bad++; $display("FAIL drop_cpu: got ack=%b data=%h want 1 %h", cpu_ack, cpu_rdata, ref_mem[16'h4000]);
        end
        cpu_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_en)  en_cnt++;
            if (dma_ack) dack_cnt++;
        end
        total++;
        if (en_cnt !== 0) begin bad++; $display("FAIL drop_mem_en: got %0d accesses want 0", en_cnt); end
        total++;
        if (dack_cnt !== 0) begin bad++; $display("FAIL drop_dma_ack: got %0d acks want 0", dack_cnt); end
    endtask

    // Random traffic from both requesters against the transaction model.
    task automatic test_random();
        txn_t        pm, pa;
        bit          last_dma, cp, dp, cg, dg, ack_c, ack_d, take_dma;
        int          busy, model_acks, dut_acks;
        logic [15:0] exp_crd, exp_drd;
        apply_reset();
        for (int i = 0; i < 16; i++) preload(16'h0100 + 16'(i), 16'($urandom));
        pm = '0; pa = '0;
        last_dma = 1'b1; cp = 1'b0; dp = 1'b0; cg = 1'b0; dg = 1'b0;
        busy = 0; model_acks = 0; dut_acks = 0;
        exp_crd = 16'h0000; exp_drd = 16'h0000;
        for (int c = 0; c < 600; c++) begin
            total++;
            if (mem_en !== pm.valid) begin
                bad++; $display("FAIL rand_mem_en@%0d: got %b want %b", c, mem_en, pm.valid);
            end
            if (pm.valid) begin
                total++;
                if ({mem_we, mem_addr, mem_wdata} !== {pm.wr, pm.addr, pm.wdata}) begin
                    bad++; $display("FAIL rand_cmd@%0d: got %b %h %h want %b %h %h", c,
                                    mem_we, mem_addr, mem_wdata, pm.wr, pm.addr, pm.wdata);
                end
            end
            ack_c = pa.valid && !pa.dma;
            ack_d = pa.valid &&  pa.dma;
            if (cpu_ack) dut_acks++;
            if (dma_ack) dut_acks++;
            total++;
            if ({cpu_ack, dma_ack} !== {ack_c, ack_d}) begin
                bad++; $display("FAIL rand_ack@%0d: got %b%b want %b%b", c, cpu_ack, dma_ack, ack_c, ack_d);
            end
            if (ack_c && !pa.wr) exp_crd = pa.rdata;
            if (ack_d && !pa.wr) exp_drd = pa.rdata;
            total++;
            if (cpu_rdata !== exp_crd) begin
                bad++; $display("FAIL rand_cpu_rdata@%0d: got %h want %h", c, cpu_rdata, exp_crd);
            end
            total++;
            if (dma_rdata !== exp_drd) begin
                bad++; $display("FAIL rand_dma_rdata@%0d: got %h want %h", c, dma_rdata, exp_drd);
            end
            if (ack_c) begin cp = 1'b0; cg = 1'b0; model_acks++; end
            if (ack_d) begin dp = 1'b0; dg = 1'b0; model_acks++; end
            pa = pm;
            pm = '0;

            // Requesters: start a new access now and then. Occasionally give up
            // before being granted.
            if (!cp) begin
                if ($urandom_range(0, 2) == 0) begin
                    cp = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
                    cpu_addr = 16'h0100 + 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
                end
            end else if (!cg && $urandom_range(0, 15) == 0) begin
                cp = 1'b0;
            end
            if (!dp) begin
                if ($urandom_range(0, 2) == 0) begin
                    dp = 1'b1; dma_wr = 1'($urandom_range(0, 1));
                    dma_addr = 16'h0100 + 16'($urandom_range(0, 15)); dma_wdata = 16'($urandom);
                end
            end else if (!dg && $urandom_range(0, 15) == 0) begin
                dp = 1'b0;
            end
            cpu_req = cp;
            dma_req = dp;

            // Model: a free slot takes a request. The slot is busy for the
            // next two cycles (command, then response).
            if (busy == 0 && (cp || dp)) begin
                take_dma = pick_dma(cp, dp, last_dma);
                last_dma = take_dma;
                pm.valid = 1'b1;
                pm.dma   = take_dma;
                pm.wr    = take_dma ? dma_wr    : cpu_wr;
                pm.addr  = take_dma ? dma_addr  : cpu_addr;
                pm.wdata = take_dma ? dma_wdata : cpu_wdata;
                if (pm.wr) ref_mem[pm.addr] = pm.wdata;
                else       pm.rdata = ref_mem[pm.addr];
                if (take_dma) dg = 1'b1; else cg = 1'b1;
                busy = 2;
            end else if (busy > 0) begin
                busy--;
            end
            #1;
            total++;
            if (cpu_stall !== (cp && !ack_c)) begin
                bad++; $display("FAIL rand_stall@%0d: got %b want %b", c, cpu_stall, cp && !ack_c);
            end
            tick();
        end
        idle_inputs();
        tick();
        tick();
        total++;
        if (dut_acks !== model_acks) begin
            bad++; $display("FAIL rand_ack_count: got %0d want %0d", dut_acks, model_acks);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_priority();
        test_reset_abort();
        test_dma_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
